// File: rtl/rager_pkg.sv
// Shared keycodes, edge-mode and FSM encodings for the sprite motion controller.
package rager_pkg;

    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_ENTER = 8'h28;
    localparam logic [7:0] KEY_P     = 8'h13;

    typedef enum logic [1:0] {
        MODE_CLAMP  = 2'd0,
        MODE_WRAP   = 2'd1,
        MODE_BOUNCE = 2'd2
    } motion_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } motion_state_t;

    // A zero slot is "no key" and never matches.
    function automatic logic key_hit(input logic [7:0] slot, input logic [7:0] code);
        return (slot != 8'h00) && (slot == code);
    endfunction

endpackage

// File: rtl/sprite_motion_axis_step.sv
// One-axis position step: applies a signed delta and resolves the playfield edge
// according to the clamp / wrap / bounce mode.
module axis_step
    import rager_pkg::*;
#(
    parameter int MIN     = 0,
    parameter int MAX     = 639,
    parameter int SIZE    = 16,
    parameter int MODE    = 0,
    parameter int COORD_W = 10
) (
    input  logic [COORD_W-1:0]        pos_i,
    input  logic signed [COORD_W+1:0] d_i,
    input  logic signed [COORD_W+1:0] vel_i,
    output logic [COORD_W-1:0]        pos_o,
    output logic signed [COORD_W+1:0] vel_o
);

    localparam int W = COORD_W + 2;
    localparam logic signed [W-1:0] LO = W'(MIN);
    localparam logic signed [W-1:0] HI = W'(MAX - SIZE + 1);
    localparam logic IS_WRAP   = (MODE == int'(MODE_WRAP));
    localparam logic IS_BOUNCE = (MODE == int'(MODE_BOUNCE));

    logic signed [W-1:0] pos_ext;
    logic signed [W-1:0] step;
    logic signed [W-1:0] cand;
    logic signed [W-1:0] bounded;

    always_comb begin
        pos_ext = signed'({2'b00, pos_i});
        step    = d_i;
        // In bounce mode the stored velocity keeps the sprite moving with no key held.
        if (IS_BOUNCE && (d_i == '0)) begin
            step = vel_i;
        end
        cand    = pos_ext + step;
        bounded = cand;
        vel_o   = step;
        if (cand < LO) begin
            bounded = IS_WRAP ? HI : LO;
            if (IS_BOUNCE) begin
                vel_o = -step;
            end
        end else if (cand > HI) begin
            bounded = IS_WRAP ? LO : HI;
            if (IS_BOUNCE) begin
                vel_o = -step;
            end
        end
        pos_o = bounded[COORD_W-1:0];
    end

endmodule

// File: rtl/sprite_motion.sv
// Per-frame sprite motion controller: detects frame ticks from vsync, decodes the
// keycode slots and runs the IDLE/RUN/PAUSE machine that gates movement.
module sprite_motion
    import rager_pkg::*;
#(
    parameter int NUM_KEYS = 3,
    parameter int COORD_W  = 10,
    parameter int X_MIN    = 0,
    parameter int X_MAX    = 639,
    parameter int Y_MIN    = 0,
    parameter int Y_MAX    = 479,
    parameter int X_INIT   = 320,
    parameter int Y_INIT   = 240,
    parameter int SIZE     = 16,
    parameter int STEP     = 2,
    parameter int MODE     = 0
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    vs,
    input  logic [NUM_KEYS*8-1:0]   keycodes,
    output logic [COORD_W-1:0]      Pos_X,
    output logic [COORD_W-1:0]      Pos_Y,
    output logic                    Start,
    output logic                    Paused,
    output logic                    Frame_tick,
    output logic [1:0]              dbg_state_o
);

    localparam int W = COORD_W + 2;
    localparam logic [COORD_W-1:0]  X_INIT_C = COORD_W'(X_INIT);
    localparam logic [COORD_W-1:0]  Y_INIT_C = COORD_W'(Y_INIT);
    localparam logic signed [W-1:0] STEP_S   = W'(STEP);

    motion_state_t       state_q, state_d;
    logic [COORD_W-1:0]  pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic signed [W-1:0] vel_x_q, vel_x_d, vel_y_q, vel_y_d;
    logic                p_prev_q, p_prev_d;
    logic                vs_q, vs_prev_q;

    logic key_up, key_left, key_down, key_right, key_enter, key_p;
    logic [7:0] slot;
    logic p_rise;
    logic signed [W-1:0] dx, dy;
    logic [COORD_W-1:0]  step_x, step_y;
    logic signed [W-1:0] step_vx, step_vy;

    // Edge detector on the registered sync: prev high, current low.
    assign Frame_tick = vs_prev_q & ~vs_q;

    always_comb begin
        slot      = '0;
        key_up    = 1'b0;
        key_left  = 1'b0;
        key_down  = 1'b0;
        key_right = 1'b0;
        key_enter = 1'b0;
        key_p     = 1'b0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            slot      = keycodes[8*k +: 8];
            key_up    = key_up    | key_hit(slot, KEY_W);
            key_left  = key_left  | key_hit(slot, KEY_A);
            key_down  = key_down  | key_hit(slot, KEY_S);
            key_right = key_right | key_hit(slot, KEY_D);
            key_enter = key_enter | key_hit(slot, KEY_ENTER);
            key_p     = key_p     | key_hit(slot, KEY_P);
        end
    end

    // Opposing keys on one axis cancel.
    always_comb begin
        dx = '0;
        dy = '0;
        if (key_right && !key_left) begin
            dx = STEP_S;
        end else if (key_left && !key_right) begin
            dx = -STEP_S;
        end
        if (key_down && !key_up) begin
            dy = STEP_S;
        end else if (key_up && !key_down) begin
            dy = -STEP_S;
        end
    end

    assign p_rise = key_p & ~p_prev_q;

    axis_step #(
        .MIN     (X_MIN),
        .MAX     (X_MAX),
        .SIZE    (SIZE),
        .MODE    (MODE),
        .COORD_W (COORD_W)
    ) u_axis_x (
        .pos_i (pos_x_q),
        .d_i   (dx),
        .vel_i (vel_x_q),
        .pos_o (step_x),
        .vel_o (step_vx)
    );

    axis_step #(
        .MIN     (Y_MIN),
        .MAX     (Y_MAX),
        .SIZE    (SIZE),
        .MODE    (MODE),
        .COORD_W (COORD_W)
    ) u_axis_y (
        .pos_i (pos_y_q),
        .d_i   (dy),
        .vel_i (vel_y_q),
        .pos_o (step_y),
        .vel_o (step_vy)
    );

    always_comb begin
        state_d  = state_q;
        pos_x_d  = pos_x_q;
        pos_y_d  = pos_y_q;
        vel_x_d  = vel_x_q;
        vel_y_d  = vel_y_q;
        p_prev_d = p_prev_q;
        if (Frame_tick) begin
            // P history tracks every tick, so ENTER+P from IDLE counts P as held.
            p_prev_d = key_p;
            case (state_q)
                IDLE: begin
                    pos_x_d = X_INIT_C;
                    pos_y_d = Y_INIT_C;
                    if (key_enter) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (p_rise) begin
                        state_d = PAUSE;
                    end else begin
                        pos_x_d = step_x;
                        pos_y_d = step_y;
                        vel_x_d = step_vx;
                        vel_y_d = step_vy;
                    end
                end
                PAUSE: begin
                    if (p_rise) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            pos_x_q   <= X_INIT_C;
            pos_y_q   <= Y_INIT_C;
            vel_x_q   <= '0;
            vel_y_q   <= '0;
            p_prev_q  <= 1'b0;
            vs_q      <= 1'b1;
            vs_prev_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            vel_x_q   <= vel_x_d;
            vel_y_q   <= vel_y_d;
            p_prev_q  <= p_prev_d;
            vs_q      <= vs;
            vs_prev_q <= vs_q;
        end
    end

    assign Pos_X       = pos_x_q;
    assign Pos_Y       = pos_y_q;
    assign Start       = (state_q != IDLE);
    assign Paused      = (state_q == PAUSE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sprite_motion.sv
// Directed bench for sprite_motion: one default instance plus clamp, wrap and
// bounce instances started near the edges they exercise.
module tb_sprite_motion;

    localparam logic [7:0] K_W = 8'h1A;
    localparam logic [7:0] K_A = 8'h04;
    localparam logic [7:0] K_S = 8'h16;
    localparam logic [7:0] K_D = 8'h07;
    localparam logic [7:0] K_E = 8'h28;
    localparam logic [7:0] K_P = 8'h13;
    localparam logic [7:0] K_0 = 8'h00;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        vs  = 1'b1;
    logic [23:0] kc_m = '0, kc_c = '0, kc_w = '0, kc_b = '0;

    logic [9:0] m_x, m_y, c_x, c_y, w_x, w_y, b_x, b_y;
    logic       m_start, m_paused, m_tick, c_start, c_paused, c_tick;
    logic       w_start, w_paused, w_tick, b_start, b_paused, b_tick;
    logic [1:0] m_dbg, c_dbg, w_dbg, b_dbg;

    int n_checks = 0;
    int n_errors = 0;
    int frames_sent = 0;
    int tick_cnt = 0;

    always #5 clk = ~clk;

    sprite_motion u_main (
        .Clk(clk), .Reset(rst), .vs(vs), .keycodes(kc_m),
        .Pos_X(m_x), .Pos_Y(m_y), .Start(m_start), .Paused(m_paused),
        .Frame_tick(m_tick), .dbg_state_o(m_dbg)
    );

    sprite_motion #(.X_INIT(622), .Y_INIT(1), .MODE(0)) u_clamp (
        .Clk(clk), .Reset(rst), .vs(vs), .keycodes(kc_c),
        .Pos_X(c_x), .Pos_Y(c_y), .Start(c_start), .Paused(c_paused),
        .Frame_tick(c_tick), .dbg_state_o(c_dbg)
    );

    sprite_motion #(.X_INIT(623), .MODE(1)) u_wrap (
        .Clk(clk), .Reset(rst), .vs(vs), .keycodes(kc_w),
        .Pos_X(w_x), .Pos_Y(w_y), .Start(w_start), .Paused(w_paused),
        .Frame_tick(w_tick), .dbg_state_o(w_dbg)
    );

    sprite_motion #(.Y_INIT(461), .MODE(2)) u_bounce (
        .Clk(clk), .Reset(rst), .vs(vs), .keycodes(kc_b),
        .Pos_X(b_x), .Pos_Y(b_y), .Start(b_start), .Paused(b_paused),
        .Frame_tick(b_tick), .dbg_state_o(b_dbg)
    );

    always @(negedge clk) begin
        if (m_tick) tick_cnt++;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_main(input string tag, input int ex, input int ey,
                              input int est, input int ep);
        check_eq({tag, "_x"}, int'(m_x), ex);
        check_eq({tag, "_y"}, int'(m_y), ey);
        check_eq({tag, "_start"}, int'(m_start), est);
        check_eq({tag, "_paused"}, int'(m_paused), ep);
    endtask

    task automatic reset_dut();
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
    endtask

    // One vsync low pulse; tick must be high exactly one cycle, outputs settle after it.
    task automatic frame();
        @(negedge clk) vs = 1'b0;
        @(negedge clk);
        check_eq("tick_hi", int'(m_tick), 1);
        vs = 1'b1;
        @(negedge clk);
        check_eq("tick_lo", int'(m_tick), 0);
        repeat (2) @(negedge clk);
        frames_sent++;
    endtask

    initial begin
        reset_dut();
        check_main("rst", 320, 240, 0, 0);
        check_eq("rst_tick", int'(m_tick), 0);
        check_eq("rst_dbg", int'(m_dbg), 0);
        check_eq("rst_clamp_x", int'(c_x), 622);
        check_eq("rst_clamp_y", int'(c_y), 1);

        frame();
        check_main("idle1", 320, 240, 0, 0);
        frame();
        check_main("idle2", 320, 240, 0, 0);
        check_eq("idle_ticks", tick_cnt, 2);
        kc_m = {K_0, K_0, K_D};
        frame();
        check_main("idle_key", 320, 240, 0, 0);

        kc_m = {K_E, K_0, K_0};
        kc_c = {K_0, K_0, K_E};
        kc_w = {K_0, K_0, K_E};
        kc_b = {K_0, K_0, K_E};
        frame();
        check_main("start", 320, 240, 1, 0);
        check_eq("start_dbg", int'(m_dbg), 1);
        check_eq("start_c", int'(c_start), 1);
        check_eq("start_w", int'(w_start), 1);
        check_eq("start_b", int'(b_start), 1);

        kc_m = {K_0, K_0, K_D}; kc_c = {K_0, K_0, K_D};
        kc_w = {K_0, K_0, K_D}; kc_b = {K_0, K_0, K_S};
        frame();
        check_main("mv1", 322, 240, 1, 0);
        check_eq("clamp_x1", int'(c_x), 624);
        check_eq("wrap_hi", int'(w_x), 0);
        check_eq("bnc_y1", int'(b_y), 463);

        kc_w = {K_0, K_0, K_A}; kc_b = '0;
        frame();
        check_main("mv2", 324, 240, 1, 0);
        check_eq("clamp_x2", int'(c_x), 624);
        check_eq("wrap_lo", int'(w_x), 624);
        check_eq("bnc_y2", int'(b_y), 464);

        kc_c = {K_0, K_0, K_W}; kc_w = '0;
        frame();
        check_main("mv3", 326, 240, 1, 0);
        check_eq("clamp_x3", int'(c_x), 624);
        check_eq("clamp_y0", int'(c_y), 0);
        check_eq("wrap_hold", int'(w_x), 624);
        check_eq("bnc_y3", int'(b_y), 462);

        kc_m = {K_0, K_A, K_D};
        frame();
        check_main("cancel", 326, 240, 1, 0);
        check_eq("clamp_y_sat", int'(c_y), 0);
        check_eq("bnc_y4", int'(b_y), 460);
        kc_c = '0;

        kc_m = {K_0, K_S, K_D};
        frame();
        check_main("diag", 328, 242, 1, 0);

        kc_m = {K_0, K_0, K_P};
        frame();
        check_main("pause", 328, 242, 1, 1);
        check_eq("pause_dbg", int'(m_dbg), 2);
        kc_m = {K_0, K_D, K_P};
        frame();
        check_main("p_held1", 328, 242, 1, 1);
        kc_m = {K_0, K_0, K_P};
        frame();
        check_main("p_held2", 328, 242, 1, 1);
        frame();
        check_main("p_held3", 328, 242, 1, 1);
        kc_m = {K_0, K_E, K_D};
        frame();
        check_main("p_enter", 328, 242, 1, 1);
        kc_m = {K_0, K_0, K_P};
        frame();
        check_main("resume", 328, 242, 1, 0);
        kc_m = {K_D, K_0, K_0};
        frame();
        check_main("mv_slot2", 330, 242, 1, 0);

        kc_m = {K_0, K_0, K_D};
        repeat (3) @(negedge clk);
        kc_m = '0;
        frame();
        check_main("between", 330, 242, 1, 0);

        kc_m = {K_0, K_0, K_P};
        frame();
        check_main("pause2", 330, 242, 1, 1);
        reset_dut();
        check_main("rst_pause", 320, 240, 0, 0);
        check_eq("rst_pause_dbg", int'(m_dbg), 0);

        kc_m = {K_0, K_P, K_E};
        frame();
        check_main("enter_p", 320, 240, 1, 0);
        kc_m = {K_0, K_0, K_P};
        frame();
        check_main("p_prehold", 320, 240, 1, 0);
        kc_m = '0;
        frame();
        kc_m = {K_0, K_0, K_P};
        frame();
        check_main("pause3", 320, 240, 1, 1);

        check_eq("tick_count", tick_cnt, frames_sent);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
